// File: rtl/mux4_rr_sched_pkg.sv
// Shared encodings and defaults for the round-robin 4:1 mux scheduler.
package mux4_rr_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int unsigned HOLD_MAX_DEFAULT = 4;

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational rotating priority pick: first set bit of req_i scanning base_i, base_i+1, ...
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] base_i,
  output logic       found_o,
  output logic [1:0] idx_o
);

  always_comb begin
    logic [1:0] cand;
    cand    = base_i;
    found_o = 1'b0;
    idx_o   = base_i;
    // Scan from the far end so the candidate closest to base_i wins.
    for (int k = 3; k >= 0; k--) begin
      cand = base_i + 2'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler time-sharing one 4:1 single-bit mux, with a bounded hold per owner.
module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       i3_i,
  input  logic       i2_i,
  input  logic       i1_i,
  input  logic       i0_i,
  output logic [3:0] gnt_o,
  output logic       s1_o,
  output logic       s0_o,
  output logic       valid_o,
  output logic       z_o
);

  state_e     state_q;
  logic [3:0] hold_q;
  logic [1:0] last_q;
  logic [1:0] sel_q;
  logic [3:0] gnt_q;
  logic       valid_q;

  logic [1:0] base_new;
  logic [1:0] base_sw;
  logic [3:0] req_other;
  logic       new_found;
  logic [1:0] new_idx;
  logic       sw_found;
  logic [1:0] sw_idx;
  logic [3:0] data_vec;

  assign base_new  = last_q + 2'd1;
  assign base_sw   = sel_q + 2'd1;
  // gnt_q is the owner's one-hot while granted, so this masks out the owner.
  assign req_other = req_i & ~gnt_q;

  rr_pick4 u_pick_new (
    .req_i   (req_i),
    .base_i  (base_new),
    .found_o (new_found),
    .idx_o   (new_idx)
  );

  rr_pick4 u_pick_sw (
    .req_i   (req_other),
    .base_i  (base_sw),
    .found_o (sw_found),
    .idx_o   (sw_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= 4'd0;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (new_found) begin
            state_q <= ST_GRANT;
            hold_q  <= 4'd1;
            last_q  <= new_idx;
            sel_q   <= new_idx;
            gnt_q   <= 4'b0001 << new_idx;
            valid_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (req_i[sel_q] && (hold_q < 4'(HOLD_MAX))) begin
            hold_q <= hold_q + 4'd1;
          end else if (sw_found) begin
            hold_q <= 4'd1;
            last_q <= sw_idx;
            sel_q  <= sw_idx;
            gnt_q  <= 4'b0001 << sw_idx;
          end else if (req_i[sel_q]) begin
            hold_q <= 4'd1;
          end else begin
            state_q <= ST_IDLE;
            hold_q  <= 4'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 4'b0000;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_vec = {i3_i, i2_i, i1_i, i0_i};
  assign z_o      = valid_q & data_vec[sel_q];
  assign gnt_o    = gnt_q;
  assign s1_o     = sel_q[1];
  assign s0_o     = sel_q[0];
  assign valid_o  = valid_q;

endmodule
